// File: rtl/shifter_pkg.sv
// Shared constants and one-hot select helpers for the pipelined right shifter.
// No ports. XLEN and SHAMT_W fix the datapath and shift-amount widths.
// onehot4 and onehot8 turn a binary shift amount into the one-hot select
// used by the AND-OR diagonal shift networks.
package shifter_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;

  // 3-bit binary to 8-bit one-hot. This is the fine bit-shift select.
  function automatic logic [7:0] onehot8(input logic [2:0] sel);
    onehot8 = 8'd1 << sel;
  endfunction

  // 2-bit binary to 4-bit one-hot. This is the coarse byte-shift select.
  function automatic logic [3:0] onehot4(input logic [1:0] sel);
    onehot4 = 4'd1 << sel;
  endfunction

endpackage

// File: rtl/onehot_shift_right.sv
// Combinational one-hot right shifter built as an AND-OR diagonal.
// Ports:
//   s    in  MAXSH  one-hot shift select. s[k] selects a shift of k.
//   din  in  WIDTH  data to shift toward bit 0.
//   fill in  1      value shifted in at the top.
//   dout out WIDTH  dout[i] = OR over k of s[k] & (i+k<WIDTH ? din[i+k] : fill)
module onehot_shift_right #(
  parameter int WIDTH = 32,
  parameter int MAXSH = 8
) (
  input  logic [MAXSH-1:0] s,
  input  logic [WIDTH-1:0] din,
  input  logic             fill,
  output logic [WIDTH-1:0] dout
);

  genvar gi, gk;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [MAXSH-1:0] w_term;
      for (gk = 0; gk < MAXSH; gk++) begin : g_tap
        // A tap that reaches past the top of din picks up the fill bit instead.
        if (gi + gk < WIDTH) begin : g_data
          assign w_term[gk] = s[gk] & din[gi+gk];
        end else begin : g_fill
          assign w_term[gk] = s[gk] & fill;
        end
      end
      assign dout[gi] = |w_term;
    end
  endgenerate

endmodule

// File: rtl/shifter_right_pipe.sv
// Two-stage pipelined 32-bit right shifter (SRL/SRA) with valid/ready on both sides.
// Stage 1 registers a coarse byte shift. Stage 2 registers the fine 0..7 bit shift.
// Ports:
//   clk       in   1      clock, rising edge
//   rst_n     in   1      synchronous reset, active-low
//   in_valid  in   1      upstream presents an operation
//   in_ready  out  1      operation is accepted this cycle
//   in_data   in   32     operand
//   in_shamt  in   5      shift amount 0..31
//   in_arith  in   1      1 = arithmetic (sign fill), 0 = logical (zero fill)
//   out_valid out  1      out_data holds a result
//   out_ready in   1      downstream takes the result this cycle
//   out_data  out  32     shifted result
module shifter_right_pipe
  import shifter_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic               in_arith,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_data
);

  // Stage 1 state
  logic            r_s1_valid;
  logic [XLEN-1:0] r_s1_data;
  logic [7:0]      r_s1_fine;
  logic            r_s1_fill;

  // Stage 2 state, which drives the outputs
  logic            r_s2_valid;
  logic [XLEN-1:0] r_s2_data;

  logic            w_fill;
  logic [3:0]      w_byte_sel;
  logic [XLEN-1:0] w_byte_shifted;
  logic [XLEN-1:0] w_fine_shifted;
  logic            w_s2_adv;

  assign w_fill     = in_arith & in_data[XLEN-1];
  assign w_byte_sel = onehot4(in_shamt[4:3]);

  // The byte shift is done as eight 4-lane shifters, one per bit position
  // inside a byte. Lane j of plane gi carries bit 8*j+gi.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_plane
      logic [3:0] w_lane_in;
      logic [3:0] w_lane_out;

      assign w_lane_in = {in_data[24+gi], in_data[16+gi], in_data[8+gi], in_data[gi]};

      onehot_shift_right #(
        .WIDTH (4),
        .MAXSH (4)
      ) u_byte_stage (
        .s    (w_byte_sel),
        .din  (w_lane_in),
        .fill (w_fill),
        .dout (w_lane_out)
      );

      assign w_byte_shifted[gi]    = w_lane_out[0];
      assign w_byte_shifted[8+gi]  = w_lane_out[1];
      assign w_byte_shifted[16+gi] = w_lane_out[2];
      assign w_byte_shifted[24+gi] = w_lane_out[3];
    end
  endgenerate

  onehot_shift_right #(
    .WIDTH (XLEN),
    .MAXSH (8)
  ) u_fine_stage (
    .s    (r_s1_fine),
    .din  (r_s1_data),
    .fill (r_s1_fill),
    .dout (w_fine_shifted)
  );

  // Stage 1 can move forward when the output slot is free or is being drained.
  assign w_s2_adv = r_s1_valid & (~r_s2_valid | out_ready);
  assign in_ready = rst_n & (~r_s1_valid | w_s2_adv);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_fine  <= '0;
      r_s1_fill  <= 1'b0;
    end else if (in_ready) begin
      // When in_ready is high, stage 1 is either empty or being emptied this
      // cycle, so its valid bit follows in_valid.
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_data <= w_byte_shifted;
        r_s1_fine <= onehot8(in_shamt[2:0]);
        r_s1_fill <= w_fill;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
    end else if (w_s2_adv) begin
      // A reload covers a simultaneous output transfer, so no bubble is inserted.
      r_s2_valid <= 1'b1;
      r_s2_data  <= w_fine_shifted;
    end else if (out_ready) begin
      r_s2_valid <= 1'b0;
    end
  end

  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_data;

endmodule

// File: tb/tb_shifter_right_pipe.sv
module tb_shifter_right_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic        in_arith;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int checks = 0;
  int errors = 0;
  int n_in   = 0;
  int n_out  = 0;
  logic [31:0] model_q[$];

  shifter_right_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_arith  (in_arith),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain logical or arithmetic right shift.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] sh,
                                            input logic ar);
    logic signed [31:0] sd;
    sd = d;
    if (ar) return 32'(sd >>> sh);
    return d >> sh;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge, once the inputs are set. Samples the
  // transfers that will happen at the next rising edge, scores them, and
  // returns at the following falling edge.
  task automatic tick();
    logic in_x;
    logic out_x;
    logic [31:0] e;
    #1;
    in_x  = in_valid && in_ready;
    out_x = out_valid && out_ready;
    if (out_x) begin
      checks++;
      assert (model_q.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected: observed result 0x%08h expected no result", out_data);
      end
      if (model_q.size() != 0) begin
        e = model_q.pop_front();
        chk("sb_result", out_data, e);
        $display("out  #%0d data=0x%08h expect=0x%08h", n_out, out_data, e);
      end
      n_out++;
    end
    if (in_x) begin
      model_q.push_back(ref_shift(in_data, in_shamt, in_arith));
      n_in++;
    end
    @(negedge clk);
  endtask

  task automatic directed(input logic [31:0] d, input logic [4:0] sh, input logic ar,
                          input logic [31:0] exp, input string tag);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d;
    in_shamt  = sh;
    in_arith  = ar;
    $display("in   %s data=0x%08h shamt=%0d arith=%0d", tag, d, sh, ar);
    tick();
    in_valid = 1'b0;
    in_data  = $urandom;
    in_shamt = 5'($urandom);
    chk({tag, "_lat1_valid"}, 32'(out_valid), 32'd0);
    tick();
    chk({tag, "_lat2_valid"}, 32'(out_valid), 32'd1);
    chk(tag, out_data, exp);
    tick();
  endtask

  initial begin
    logic [31:0] held;
    logic [31:0] ops [3];
    int base;
    int cyc;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_arith  = 1'b0;
    out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Directed values and boundaries
    directed(32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001, "srl_31");
    directed(32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, "sra_31");
    directed(32'h7FFF_FFFF, 5'd4,  1'b1, 32'h07FF_FFFF, "sra_4_pos");
    directed(32'hDEAD_BEEF, 5'd0,  1'b0, 32'hDEAD_BEEF, "srl_0");
    directed(32'hDEAD_BEEF, 5'd0,  1'b1, 32'hDEAD_BEEF, "sra_0");
    directed(32'hDEAD_BEEF, 5'd8,  1'b0, 32'h00DE_ADBE, "srl_8");
    directed(32'hDEAD_BEEF, 5'd13, 1'b0, 32'h0006_F56D, "srl_13");
    directed(32'hDEAD_BEEF, 5'd13, 1'b1, 32'hFFFE_F56D, "sra_13");

    // Four back-to-back ops give four consecutive results
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = (i < 4);
      in_data  = $urandom;
      in_shamt = 5'($urandom);
      in_arith = 1'($urandom);
      chk("b2b_out_valid", 32'(out_valid), 32'(i >= 2 && i <= 5));
      tick();
    end
    in_valid = 1'b0;

    // Stall: three ops offered while the output is blocked
    for (int i = 0; i < 3; i++) ops[i] = $urandom;
    base = n_in;
    out_ready = 1'b0;
    in_arith  = 1'b1;
    in_shamt  = 5'd3;
    held      = '0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = ops[n_in - base];
      #1;
      chk("stall_in_ready", 32'(in_ready), 32'(i < 2));
      if (i >= 2) chk("stall_out_valid", 32'(out_valid), 32'd1);
      if (i == 2) held = out_data;
      if (i > 2) chk("stall_hold", out_data, held);
      tick();
    end
    chk("stall_accepts", 32'(n_in - base), 32'd2);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && (model_q.size() != 0 || n_in - base < 3); c++) begin
      in_valid = (n_in - base < 3);
      if (n_in - base < 3) in_data = ops[n_in - base];
      tick();
    end
    in_valid = 1'b0;
    chk("stall_all_accepted", 32'(n_in - base), 32'd3);
    chk("stall_drained", 32'(model_q.size()), 32'd0);

    // Reset with two operations in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_data  = $urandom;
      in_shamt = 5'($urandom);
      tick();
    end
    in_valid = 1'b0;
    chk("flight_out_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("flight_rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("flight_rst_out_valid", 32'(out_valid), 32'd0);
    chk("flight_rst_out_data", out_data, 32'd0);
    chk("flight_rst_in_ready2", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    model_q.delete();
    #1;
    chk("flight_post_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("flight_no_stale", 32'(out_valid), 32'd0);
      tick();
    end

    // Random ops with random backpressure against the reference model
    base = n_in;
    cyc  = 0;
    while (n_in - base < 10000 && cyc < 60000) begin
      in_valid  = ($urandom_range(3) != 0);
      in_data   = $urandom;
      in_shamt  = 5'($urandom);
      in_arith  = 1'($urandom);
      out_ready = ($urandom_range(9) < 7);
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("rand_issued", 32'(n_in - base), 32'd10000);
    for (int c = 0; c < 10 && model_q.size() != 0; c++) tick();
    chk("rand_drained", 32'(model_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
